// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// segment bit order, the blank pattern and the hex glyph table (all active-low).
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Index 0 is the rightmost element: HEX_SEG[n] is the glyph for nibble n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bus of the scan driver: shadow inputs, brightness and the
// multiplexed digit/segment outputs.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                       mode;
    logic                       load;
    logic [NUM_DIGITS-1:0][3:0] hex_in;
    logic [NUM_DIGITS-1:0][7:0] raw_in;
    logic [NUM_DIGITS-1:0]      dp_in;
    logic [NUM_DIGITS-1:0]      blank_in;
    logic [NUM_DIGITS-1:0]      blink_in;
    logic [2:0]                 bright;
    logic [NUM_DIGITS-1:0]      seg_en;
    logic [7:0]                 seg_out;
    logic                       frame_done;

    modport master (
        output mode, load, hex_in, raw_in, dp_in, blank_in, blink_in, bright,
        input  seg_en, seg_out, frame_done
    );

    modport slave (
        input  mode, load, hex_in, raw_in, dp_in, blank_in, blink_in, bright,
        output seg_en, seg_out, frame_done
    );
endinterface

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment glyph; an active-high dp lights the point.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);
    always_comb begin
        seg = HEX_SEG[nibble];
        if (dp) seg[SEG_DP] = 1'b0;
    end
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: slot/digit scan, frame-synchronous
// shadow-to-active update, dead-time, PWM brightness and blinking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input logic             clk,
    input logic             rst,
    seg_scan_driver_if.slave bus
);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W  = $clog2(2 * BLINK_FRAMES);
    localparam int DUTY_W = SLOT_W + 4;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(2 * BLINK_FRAMES - 1);
    localparam logic [BLK_W-1:0]  BLK_HALF  = BLK_W'(BLINK_FRAMES);
    localparam logic [DUTY_W-1:0] LIT_SPAN  = DUTY_W'(SCAN_DIV - BLANK_CYC);

    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  idx;
    logic [BLK_W-1:0]  blk_cnt;
    logic              pending;

    logic                       mode_sh,  mode_act;
    logic [NUM_DIGITS-1:0][3:0] hex_sh,   hex_act;
    logic [NUM_DIGITS-1:0][7:0] raw_sh,   raw_act;
    logic [NUM_DIGITS-1:0]      dp_sh,    dp_act;
    logic [NUM_DIGITS-1:0]      blank_sh, blank_act;
    logic [NUM_DIGITS-1:0]      blink_sh, blink_act;

    logic [NUM_DIGITS-1:0] en_q;
    logic [7:0]            seg_q;
    logic                  done_q;

    logic              slot_wrap, boundary, blink_off, lit;
    logic [DUTY_W-1:0] phase8, duty_lim;
    logic [7:0]        hex_seg, cur_seg;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign boundary  = slot_wrap && (idx == IDX_LAST);
    assign blink_off = (blk_cnt >= BLK_HALF);

    // Duty compare done as p*8 < span*(bright+1) to avoid a divider;
    // DUTY_W leaves headroom for span*8 at any legal SCAN_DIV.
    assign phase8   = DUTY_W'(slot_cnt - BLANK_END) << 3;
    assign duty_lim = LIT_SPAN * DUTY_W'({1'b0, bus.bright} + 4'd1);

    seg_hex_decode u_dec (
        .nibble (hex_act[idx]),
        .dp     (dp_act[idx]),
        .seg    (hex_seg)
    );

    assign cur_seg = mode_act ? raw_act[idx] : hex_seg;

    assign lit = !blank_act[idx]
              && !(blink_act[idx] && blink_off)
              && (slot_cnt >= BLANK_END)
              && (phase8 < duty_lim);

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_cnt  <= '0;
            idx       <= '0;
            blk_cnt   <= '0;
            pending   <= 1'b0;
            mode_sh   <= 1'b0;
            hex_sh    <= '0;
            raw_sh    <= '0;
            dp_sh     <= '0;
            blank_sh  <= '0;
            blink_sh  <= '0;
            mode_act  <= 1'b0;
            hex_act   <= '0;
            raw_act   <= '0;
            dp_act    <= '0;
            blank_act <= '1;
            blink_act <= '0;
            en_q      <= '1;
            seg_q     <= SEG_OFF;
            done_q    <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (boundary)  blk_cnt <= (blk_cnt == BLK_LAST) ? '0 : blk_cnt + 1'b1;

            if (bus.load) begin
                mode_sh  <= bus.mode;
                hex_sh   <= bus.hex_in;
                raw_sh   <= bus.raw_in;
                dp_sh    <= bus.dp_in;
                blank_sh <= bus.blank_in;
                blink_sh <= bus.blink_in;
            end

            // A load landing on the boundary itself rolls over to the next frame.
            if (boundary && pending) begin
                mode_act  <= mode_sh;
                hex_act   <= hex_sh;
                raw_act   <= raw_sh;
                dp_act    <= dp_sh;
                blank_act <= blank_sh;
                blink_act <= blink_sh;
                pending   <= bus.load;
            end else if (bus.load) begin
                pending <= 1'b1;
            end

            en_q   <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg_q  <= lit ? cur_seg : SEG_OFF;
            done_q <= boundary;
        end
    end

    assign bus.seg_en     = en_q;
    assign bus.seg_out    = seg_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-position reference model checked every cycle,
// plus a vector table and hand sequences for loads, blink, boundary and reset.
module tb_seg_scan_driver;
    localparam int ND = 4, SD = 32, BC = 4, BF = 2, FL = ND * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(ND)) bus();

    seg_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        mode;
        logic [15:0] hex;
        logic [31:0] raw;
        logic [3:0]  dp, blank, blink;
    } cfg_t;

    typedef struct {
        int   cyc;
        cfg_t cfg;
    } load_t;

    typedef struct {
        cfg_t       cfg;
        logic [2:0] bright;
        int         digit, slot;
        logic [3:0] exp_en;
        logic [7:0] exp_seg;
    } vec_t;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int    vec_cnt = 0;
    int    err_cnt = 0;
    int    k = 0;          // cycles since reset release = next scan position
    load_t loads[$];
    vec_t  tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            if (err_cnt <= 40)
                $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for scan position kk: frame/digit/slot come from plain
    // division, the active config is the last load strictly before the boundary.
    function automatic void model(input int kk, input logic [2:0] b,
                                  output logic [3:0] en, output logic [7:0] sg);
        int   f, slot, dig, p;
        cfg_t c;
        bit   have;
        f = kk / FL; slot = kk % SD; dig = (kk / SD) % ND; p = slot - BC;
        have = 0;
        foreach (loads[i]) if (loads[i].cyc < f * FL - 1) begin c = loads[i].cfg; have = 1; end
        en = 4'hF; sg = 8'hFF;
        if (!have) return;
        if (c.blank[dig]) return;
        if (c.blink[dig] && (f % (2 * BF)) >= BF) return;
        if (slot < BC || p * 8 >= (SD - BC) * (b + 1)) return;
        en[dig] = 1'b0;
        sg = c.mode ? c.raw[dig*8 +: 8]
                    : (hex_tab[c.hex[dig*4 +: 4]] & (c.dp[dig] ? 8'h7F : 8'hFF));
    endfunction

    task automatic tick();
        bit         ld, in_rst;
        logic [2:0] b;
        cfg_t       c;
        logic [3:0] een;
        logic [7:0] esg;
        ld = bus.load; in_rst = !rst; b = bus.bright;
        c.mode = bus.mode; c.hex = bus.hex_in; c.raw = bus.raw_in;
        c.dp = bus.dp_in; c.blank = bus.blank_in; c.blink = bus.blink_in;
        @(posedge clk); #1;
        if (in_rst) begin
            chk("rst_seg_en", 32'(bus.seg_en), 32'hF);
            chk("rst_seg_out", 32'(bus.seg_out), 32'hFF);
            chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
            k = 0;
            loads.delete();
        end else begin
            model(k, b, een, esg);
            chk("seg_en", 32'(bus.seg_en), 32'(een));
            chk("seg_out", 32'(bus.seg_out), 32'(esg));
            chk("frame_done", 32'(bus.frame_done), 32'((k % FL) == FL - 1));
            if (ld) loads.push_back('{k, c});
            k++;
        end
    endtask

    task automatic apply(input cfg_t c, input logic [2:0] b);
        bus.mode = c.mode; bus.hex_in = c.hex; bus.raw_in = c.raw;
        bus.dp_in = c.dp; bus.blank_in = c.blank; bus.blink_in = c.blink;
        bus.bright = b;
    endtask

    task automatic load_cfg(input cfg_t c, input logic [2:0] b);
        if (k % FL == FL - 1) tick();
        apply(c, b);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic to_next_frame();
        while (k % FL != 0) tick();
    endtask

    task automatic at_pos(input int pos);
        while (k % FL != pos) tick();
        tick();
    endtask

    function automatic cfg_t mk(input logic mode, input logic [15:0] hex, input logic [31:0] raw,
                                input logic [3:0] dp, input logic [3:0] blank, input logic [3:0] blink);
        cfg_t c;
        c.mode = mode; c.hex = hex; c.raw = raw; c.dp = dp; c.blank = blank; c.blink = blink;
        return c;
    endfunction

    task automatic add(input cfg_t c, input logic [2:0] b, input int d, input int s,
                       input logic [3:0] en, input logic [7:0] sg);
        tbl.push_back('{c, b, d, s, en, sg});
    endtask

    initial begin
        cfg_t c1, c2, c3, c4, c5, c6, cb, c55, c66, cr;
        int   cnt, lit0, lit2, f;

        c1  = mk(1'b0, 16'h1234, 32'h0, 4'h0, 4'h0, 4'h0);
        c2  = mk(1'b0, 16'hABCD, 32'h0, 4'b0010, 4'h0, 4'h0);
        c3  = mk(1'b0, 16'h0EF0, 32'h0, 4'b0001, 4'h0, 4'h0);
        c4  = mk(1'b1, 16'h0, 32'h11227F44, 4'hF, 4'h0, 4'h0);
        c5  = mk(1'b1, 16'h0, 32'h11227F44, 4'hF, 4'b0010, 4'h0);
        c6  = mk(1'b0, 16'h5678, 32'h0, 4'h0, 4'h0, 4'h0);
        cb  = mk(1'b0, 16'h1234, 32'h0, 4'h0, 4'h0, 4'b0100);
        c55 = mk(1'b0, 16'h5555, 32'h0, 4'h0, 4'h0, 4'h0);
        c66 = mk(1'b0, 16'h6666, 32'h0, 4'h0, 4'h0, 4'h0);

        add(c1, 3'd7, 0,  4, 4'b1110, 8'h99);
        add(c1, 3'd7, 0,  3, 4'b1111, 8'hFF);
        add(c1, 3'd7, 0, 31, 4'b1110, 8'h99);
        add(c1, 3'd7, 3, 10, 4'b0111, 8'hF9);
        add(c1, 3'd7, 1,  4, 4'b1101, 8'hB0);
        add(c1, 3'd3, 0, 17, 4'b1110, 8'h99);
        add(c1, 3'd3, 0, 18, 4'b1111, 8'hFF);
        add(c1, 3'd0, 0,  7, 4'b1110, 8'h99);
        add(c1, 3'd0, 0,  8, 4'b1111, 8'hFF);
        add(c2, 3'd7, 1, 20, 4'b1101, 8'h46);
        add(c2, 3'd7, 2,  5, 4'b1011, 8'h83);
        add(c2, 3'd7, 0,  5, 4'b1110, 8'hA1);
        add(c3, 3'd7, 1,  9, 4'b1101, 8'h8E);
        add(c3, 3'd7, 2,  9, 4'b1011, 8'h86);
        add(c3, 3'd7, 0,  9, 4'b1110, 8'h40);
        add(c4, 3'd7, 1, 12, 4'b1101, 8'h7F);
        add(c4, 3'd7, 3, 12, 4'b0111, 8'h11);
        add(c4, 3'd7, 0, 12, 4'b1110, 8'h44);
        add(c5, 3'd7, 1, 12, 4'b1111, 8'hFF);
        add(c5, 3'd7, 2, 12, 4'b1011, 8'h22);
        add(c6, 3'd7, 0,  4, 4'b1110, 8'h80);
        add(c6, 3'd7, 3, 30, 4'b0111, 8'h92);

        apply(mk(1'b0, 16'h0, 32'h0, 4'h0, 4'h0, 4'h0), 3'd7);
        bus.load = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // No load yet: the first frames stay dark.
        cnt = 0;
        repeat (FL + 10) begin tick(); if (bus.seg_en != 4'hF) cnt++; end
        chk("dark_before_load", 32'(cnt), 32'd0);

        foreach (tbl[i]) begin
            load_cfg(tbl[i].cfg, tbl[i].bright);
            to_next_frame();
            at_pos(tbl[i].digit * SD + tbl[i].slot);
            chk("tbl_seg_en", 32'(bus.seg_en), 32'(tbl[i].exp_en));
            chk("tbl_seg_out", 32'(bus.seg_out), 32'(tbl[i].exp_seg));
        end

        // Mid-frame loads: held until the boundary, last one wins.
        load_cfg(c1, 3'd7);
        to_next_frame();
        at_pos(40);
        load_cfg(c55, 3'd7);
        at_pos(60);
        load_cfg(c66, 3'd7);
        at_pos(3 * SD + 10);
        chk("midload_hold", 32'(bus.seg_out), 32'hF9);
        to_next_frame();
        at_pos(10);
        chk("two_loads_last", 32'(bus.seg_out), 32'h82);

        cnt = 0;
        repeat (4 * FL) begin tick(); if (bus.frame_done) cnt++; end
        chk("frame_done_count", 32'(cnt), 32'd4);

        // Blink on digit 2 only.
        load_cfg(cb, 3'd7);
        to_next_frame();
        repeat (4) begin
            f = k / FL; lit0 = 0; lit2 = 0;
            repeat (FL) begin
                tick();
                if (bus.seg_en == 4'b1011) lit2++;
                if (bus.seg_en == 4'b1110) lit0++;
            end
            chk("blink_digit2", 32'(lit2), (f % 4 < 2) ? 32'd28 : 32'd0);
            chk("blink_digit0", 32'(lit0), 32'd28);
        end

        // Load on the boundary cycle itself waits a whole extra frame.
        while (k % FL != FL - 1) tick();
        apply(c6, 3'd7);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        at_pos(10);
        chk("bnd_load_deferred", 32'(bus.seg_out), 32'h99);
        to_next_frame();
        at_pos(10);
        chk("bnd_load_applied", 32'(bus.seg_out), 32'h80);

        // Reset in the middle of a slot.
        while (k % SD != 17) tick();
        rst = 1'b0;
        tick();
        chk("midrst_seg_en", 32'(bus.seg_en), 32'hF);
        chk("midrst_seg_out", 32'(bus.seg_out), 32'hFF);
        rst = 1'b1;
        cnt = 0;
        repeat (2 * FL) begin tick(); if (bus.seg_en != 4'hF) cnt++; end
        chk("dark_after_rst", 32'(cnt), 32'd0);
        load_cfg(c1, 3'd7);
        to_next_frame();
        at_pos(4);
        chk("relit_after_rst", 32'(bus.seg_out), 32'h99);

        // Random configs, load times and per-cycle brightness.
        repeat (12 * FL) begin
            bus.bright = 3'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                cr = mk(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
                        4'($urandom) & 4'($urandom), 4'($urandom));
                apply(cr, 3'($urandom));
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        bus.load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 Parameter SCAN_DIV, default 100000: clk cycles per digit slot; SHALL be >= BLANK_CYC+8.
REQ-003 Parameter BLANK_CYC, default 16: dark dead-time at the start of each slot (anti-ghosting).
REQ-004 Parameter BLINK_FRAMES, default 64: frames per blink half-period, >= 1.
REQ-005 clk  in  1  single system clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 mode  in  1  0 = hex decode, 1 = raw segment bytes.
REQ-008 load  in  1  single-cycle strobe capturing all display inputs into the shadow registers.
REQ-009 hex_in  in  4*NUM_DIGITS  nibble i drives digit i; digit 0 is rightmost.
REQ-010 raw_in  in  8*NUM_DIGITS  byte i, active-low {dp,g,f,e,d,c,b,a}, used when mode=1.
REQ-011 dp_in  in  NUM_DIGITS  active-high decimal point per digit, used only when mode=1'b0.
REQ-012 blank_in  in  NUM_DIGITS  1 = digit permanently dark.
REQ-013 blink_in  in  NUM_DIGITS  1 = digit blinks.
REQ-014 bright  in  3  duty in eighths, (bright+1)/8; sampled directly, not shadowed.
REQ-015 seg_en  out  NUM_DIGITS  active-low digit enable, one-hot-low or all ones.
REQ-016 seg_out  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-017 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-018 slot_cnt counts 0..SCAN_DIV-1 and wraps; idx advances 0..NUM_DIGITS-1 on each slot_cnt wrap, then wraps to 0.
REQ-019 Frame boundary = cycle with idx==NUM_DIGITS-1 and slot_cnt==SCAN_DIV-1; frame length is NUM_DIGITS*SCAN_DIV cycles.
REQ-020 load sets a pending flag; at a frame boundary with pending set, the active registers (mode, hex, raw, dp, blank, blink) take the shadow contents present before that edge, and pending clears.
REQ-021 A load in the boundary cycle itself is captured into the shadow and held pending for the following boundary; with several loads in one frame, the last one wins.
REQ-022 Phase p = slot_cnt-BLANK_CYC; digit idx is lit when slot_cnt >= BLANK_CYC and p*8 < (SCAN_DIV-BLANK_CYC)*(bright+1); comparison width is sized with $clog2 and has no overflow at the maximum parameter values.
REQ-023 Blink counter counts frames modulo 2*BLINK_FRAMES; blink phase is off while counter >= BLINK_FRAMES; a digit with active blink=1 is dark during the off phase.
REQ-024 Dark (blanked, blink-off, dead-time or outside duty) SHALL drive seg_en all ones and seg_out 8'hFF.
REQ-025 Lit SHALL drive seg_en = ~(1<<idx) and seg_out = decoded pattern.
REQ-026 Hex mode pattern: full 0-F decode, 0=8'hC0, 1=8'hF9, 2=8'hA4, 3=8'hB0, 4=8'h99, 5=8'h92, 6=8'h82, 7=8'hF8, 8=8'h80, 9=8'h90, A=8'h88, b=8'h83, C=8'hC6, d=8'hA1, E=8'h86, F=8'h8E; bit 7 is cleared when the active dp=1.
REQ-027 Raw mode: seg_out = active raw byte unmodified; dp_in is ignored.
REQ-028 seg_en, seg_out and frame_done SHALL be registered, lagging counter state by exactly 1 cycle.

Reset
REQ-029 While rst=0 at an edge: slot_cnt=0, idx=0, blink counter=0, pending=0, shadow cleared, active cleared with blank all ones.
REQ-030 Outputs after reset: seg_en all ones, seg_out 8'hFF, frame_done 0.
REQ-031 Reset mid-slot or mid-frame takes effect on the next edge with no partial frame; the display stays dark until the first boundary after a load.

Structure
REQ-032 Package seg_pkg SHALL hold SEG_OFF=8'hFF, the 16-entry hex-to-segment table and the segment bit-order constants.
REQ-033 One combinational sub-module, seg_hex_decode (nibble+dp -> byte), is used; all sequential logic stays in seg_scan_driver.

Verification (NUM_DIGITS=4, SCAN_DIV=32, BLANK_CYC=4, BLINK_FRAMES=2)
REQ-034 Reset, then load hex_in=16'h1234, mode 0, bright 7 -> after the next boundary, digit-0 slot: seg_en=4'b1110, seg_out=8'h99 for slot_cnt 4..31 (+1 cycle); 8'hFF/4'hF for slot_cnt 0..3.
REQ-035 bright=3 -> lit for p=0..13 only (14 cycles); bright=0 -> p=0..3.
REQ-036 Load mid-frame -> outputs unchanged until the boundary; frame_done pulses once per 128 cycles; two loads in one frame -> the second value is displayed.
REQ-037 blink_in=4'b0100 -> digit 2 lit in frames 0-1, dark in 2-3, repeating; other digits steady.
REQ-038 mode=1, raw byte 1=8'h7F, dp_in=4'hF -> digit-1 seg_out=8'h7F; blank_in[1]=1 -> dark.
REQ-039 rst=0 at slot_cnt=17 -> next edge seg_en=4'hF, seg_out=8'hFF, counters 0, dark until load plus a boundary.
